// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_ctrl_pkg
//  Description : Shared state encoding and operand layout for the MAC batch
//                controller.
//  Revision    : 1.0  initial release
// ============================================================================
package mac_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_RD_ISSUE = 3'd2,
      S_RD_WAIT  = 3'd3,
      S_RUN      = 3'd4,
      S_SEND     = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   localparam logic [3:0] DUMP_ADDR = 4'hF;

   localparam int OPND_W = 8;
   localparam int A_LSB  = 0;
   localparam int B_LSB  = 8;
   localparam int C_LSB  = 16;

endpackage
`default_nettype wire

// File: rtl/mac.sv
`default_nettype none
// ============================================================================
//  Module      : mac
//  Description : Signed multiply-accumulate A*B+C, two cycles after en rises;
//                done stays high until en drops.
//  Revision    : 1.0  initial release
// ============================================================================
module mac #(
   parameter int A_BITWIDTH   = 8,
   parameter int OUT_BITWIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    en,
   input  logic [A_BITWIDTH-1:0]   data_a,
   input  logic [A_BITWIDTH-1:0]   data_b,
   input  logic [A_BITWIDTH-1:0]   data_c,
   output logic                    done,
   output logic [OUT_BITWIDTH-1:0] result
);

   localparam int EXT_W = OUT_BITWIDTH - A_BITWIDTH;

   logic [OUT_BITWIDTH-1:0] a_ext, b_ext, c_ext, sum;
   logic                    stage;

   assign a_ext = {{EXT_W{data_a[A_BITWIDTH-1]}}, data_a};
   assign b_ext = {{EXT_W{data_b[A_BITWIDTH-1]}}, data_b};
   assign c_ext = {{EXT_W{data_c[A_BITWIDTH-1]}}, data_c};
   assign sum   = a_ext * b_ext + c_ext;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stage  <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else if (!en) begin
         stage <= 1'b0;
         done  <= 1'b0;
      end else if (!done) begin
         if (!stage) begin
            stage <= 1'b1;
         end else begin
            result <= sum;
            done   <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mac_batch_controller_quant.sv
`default_nettype none
// ============================================================================
//  Module      : mac_quant
//  Description : Saturating 16-to-8 bit quantizer; keeps sign, takes [12:6].
//  Revision    : 1.0  initial release
// ============================================================================
module mac_quant (
   input  logic [15:0] result,
   output logic [7:0]  quant
);

   assign quant[7]   = result[15];
   assign quant[6:0] = (|result[14:13]) ? 7'h7F : result[12:6];

endmodule
`default_nettype wire

// File: rtl/sram_32x16.sv
`default_nettype none
// ============================================================================
//  Module      : sram_32x16
//  Description : 16-entry x 32-bit single-port RAM, one-cycle registered read.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_32x16 (
   input  logic        clk,
   input  logic        en,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout
);

   logic [31:0] mem [16];

   // dout only changes on a read, so it stays valid for any longer wait
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= din;
         else    dout      <= mem[addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/mac_batch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mac_batch_controller
//  Description : Buffers a batch of operand words in BRAM, then runs each
//                through the MAC and streams quantized results in order.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_batch_controller
   import mac_ctrl_pkg::*;
#(
   parameter int DEPTH  = 15,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        r_valid,
   input  logic        r_last,
   input  logic [31:0] in_data,
   output logic        r_ready,
   output logic [7:0]  out_data,
   output logic        t_valid,
   input  logic        t_ready,
   output logic        busy,
   output logic [3:0]  count
);

   localparam logic [3:0] LAST_SLOT = 4'(DEPTH - 1);
   localparam logic [3:0] FULL      = 4'(DEPTH);
   localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 1);

   state_t      state, state_nxt;
   logic        ready_en;
   logic [3:0]  rp, rd_wait;
   logic [7:0]  data_a, data_b, data_c;
   logic        mac_en, mac_done;
   logic [15:0] mac_result;
   logic [7:0]  quant;
   logic        bram_en, we, accept;
   logic [3:0]  addr;
   logic [31:0] din, dout;

   always_comb begin
      r_ready = 1'b0;
      case (state)
         S_IDLE:  r_ready = ready_en;
         S_LOAD:  r_ready = (count != FULL);
         default: r_ready = 1'b0;
      endcase
      accept  = r_valid & r_ready;
      t_valid = (state == S_SEND);
      busy    = (state != S_IDLE);
   end

   // BRAM parks on the dump address whenever it is not in use
   always_comb begin
      bram_en = 1'b0;
      we      = 1'b0;
      addr    = DUMP_ADDR;
      din     = '0;
      if (accept) begin
         bram_en = 1'b1;
         we      = 1'b1;
         addr    = count;
         din     = in_data;
      end else if (state == S_RD_ISSUE) begin
         bram_en = 1'b1;
         addr    = rp;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               if (r_last || count == LAST_SLOT) state_nxt = S_RD_ISSUE;
               else                              state_nxt = S_LOAD;
            end
         end
         S_RD_ISSUE: state_nxt = S_RD_WAIT;
         S_RD_WAIT:  if (rd_wait == WAIT_LAST) state_nxt = S_RUN;
         S_RUN:      if (mac_en && mac_done) state_nxt = S_SEND;
         S_SEND: begin
            if (t_ready) state_nxt = ((rp + 4'd1) < count) ? S_RD_ISSUE : S_DONE;
         end
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ready_en <= 1'b0;
         count    <= '0;
         rp       <= '0;
         rd_wait  <= '0;
         data_a   <= '0;
         data_b   <= '0;
         data_c   <= '0;
         mac_en   <= 1'b0;
         out_data <= '0;
      end else begin
         ready_en <= 1'b1;
         if (accept) count <= count + 4'd1;
         case (state)
            S_RD_WAIT: begin
               rd_wait <= rd_wait + 4'd1;
               if (rd_wait == WAIT_LAST) begin
                  rd_wait <= '0;
                  data_a  <= dout[A_LSB +: OPND_W];
                  data_b  <= dout[B_LSB +: OPND_W];
                  data_c  <= dout[C_LSB +: OPND_W];
                  mac_en  <= 1'b1;
               end
            end
            S_RUN: begin
               if (mac_en && mac_done) begin
                  mac_en   <= 1'b0;
                  out_data <= quant;
               end
            end
            S_SEND: if (t_ready) rp <= rp + 4'd1;
            S_DONE: begin
               count <= '0;
               rp    <= '0;
            end
            default: ;
         endcase
      end
   end

   sram_32x16 u_sram (
      .clk  (clk),
      .en   (bram_en),
      .we   (we),
      .addr (addr),
      .din  (din),
      .dout (dout)
   );

   mac #(
      .A_BITWIDTH   (8),
      .OUT_BITWIDTH (16)
   ) u_mac (
      .clk    (clk),
      .rstn   (rstn),
      .en     (mac_en),
      .data_a (data_a),
      .data_b (data_b),
      .data_c (data_c),
      .done   (mac_done),
      .result (mac_result)
   );

   mac_quant u_quant (
      .result (mac_result),
      .quant  (quant)
   );

endmodule
`default_nettype wire

// File: tb/tb_mac_batch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_batch_controller
//  Description : Self-checking bench for mac_batch_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mac_batch_controller;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        r_valid = 1'b0;
   logic        r_last = 1'b0;
   logic [31:0] in_data = '0;
   logic        t_ready = 1'b0;
   logic        r_ready, t_valid, busy;
   logic [7:0]  out_data;
   logic [3:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mac_batch_controller dut (
      .clk      (clk),
      .rstn     (rstn),
      .r_valid  (r_valid),
      .r_last   (r_last),
      .in_data  (in_data),
      .r_ready  (r_ready),
      .out_data (out_data),
      .t_valid  (t_valid),
      .t_ready  (t_ready),
      .busy     (busy),
      .count    (count)
   );

   // Reference: signed A*B+C kept to 16 bits, then saturating quantization
   function automatic logic [7:0] model_out(input logic [31:0] w);
      int a, b, c, r;
      logic [15:0] res;
      a   = int'($signed(w[7:0]));
      b   = int'($signed(w[15:8]));
      c   = int'($signed(w[23:16]));
      r   = a * b + c;
      res = r[15:0];
      return {res[15], (res[14] | res[13]) ? 7'h7F : res[12:6]};
   endfunction

   task automatic drive_batch(input logic [31:0] words[$], input bit gaps);
      int budget;
      for (int i = 0; i < words.size(); i++) begin
         if (gaps && $urandom_range(3) == 0) begin
            r_valid = 1'b0;
            @(posedge clk); #1;
         end
         r_valid = 1'b1;
         in_data = words[i];
         r_last  = (i == words.size() - 1);
         budget  = 0;
         @(negedge clk);
         while (!r_ready && budget < 50) begin
            @(negedge clk);
            budget++;
         end
         if (!r_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: word %0d r_ready=%b required 1", i, r_ready);
         end
         @(posedge clk); #1;
      end
      r_valid = 1'b0;
      r_last  = 1'b0;
   endtask

   task automatic collect(input logic [7:0] exp[$], input int bp_pct);
      int got = 0;
      int cyc = 0;
      t_ready = ($urandom_range(99) >= bp_pct);
      while (got < exp.size() && cyc < 3000) begin
         @(negedge clk);
         if (t_valid && t_ready) begin
            n_checks++;
            if (out_data !== exp[got]) begin
               n_fail++;
               $display("FAIL result[%0d]: out_data=%h required %h", got, out_data, exp[got]);
            end
            got++;
         end
         @(posedge clk); #1;
         t_ready = ($urandom_range(99) >= bp_pct);
         cyc++;
      end
      n_checks++;
      if (got != exp.size()) begin
         n_fail++;
         $display("FAIL result_count: got %0d results required %0d", got, exp.size());
      end
   endtask

   task automatic finish_idle();
      int extra = 0;
      int cyc   = 0;
      t_ready = 1'b1;
      @(negedge clk);
      while (busy && cyc < 100) begin
         if (t_valid) extra++;
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (extra != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL batch_end: extra results=%0d busy=%b required 0 and 0", extra, busy);
      end
      n_checks++;
      if (count !== 4'd0) begin
         n_fail++;
         $display("FAIL count_clear: count=%0d required 0", count);
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks++;
      if (r_ready !== 1'b0 || t_valid !== 1'b0 || busy !== 1'b0 ||
          count !== 4'd0 || out_data !== 8'h00) begin
         n_fail++;
         $display("FAIL %s: r_ready=%b t_valid=%b busy=%b count=%0d out_data=%h required 0 0 0 0 00",
                  tag, r_ready, t_valid, busy, count, out_data);
      end
   endtask

   task automatic release_reset(input string tag);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      n_checks++;
      if (r_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ready_early: r_ready=%b required 0", tag, r_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (r_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready_rise: r_ready=%b required 1", tag, r_ready);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_state");
      release_reset("reset");
   endtask

   task automatic test_single();
      logic [31:0] w[$];
      logic [7:0]  e[$];
      w.push_back(32'h0000_4040);
      e.push_back(8'h40);
      drive_batch(w, 1'b0);
      collect(e, 0);
      finish_idle();
   endtask

   task automatic test_saturation();
      logic [31:0] w[$];
      logic [7:0]  e[$];
      w.push_back(32'h0000_7F7F);
      e.push_back(8'h7F);
      drive_batch(w, 1'b0);
      collect(e, 0);
      finish_idle();
   endtask

   task automatic test_three();
      logic [31:0] w[$];
      logic [7:0]  e[$];
      w.push_back(32'h0000_4040); e.push_back(8'h40);
      w.push_back(32'h0000_2040); e.push_back(8'h20);
      w.push_back(32'h0000_7F7F); e.push_back(8'h7F);
      drive_batch(w, 1'b0);
      collect(e, 0);
      finish_idle();
   endtask

   task automatic test_full();
      logic [7:0]  e[$];
      logic [31:0] w;
      for (int i = 0; i < 16; i++) begin
         w       = $urandom;
         r_valid = 1'b1;
         r_last  = 1'b0;
         in_data = w;
         @(negedge clk);
         n_checks++;
         if (r_ready !== (i < 15)) begin
            n_fail++;
            $display("FAIL full_ready[%0d]: r_ready=%b required %b", i, r_ready, (i < 15));
         end
         if (i < 15) e.push_back(model_out(w));
         @(posedge clk); #1;
      end
      r_valid = 1'b0;
      n_checks++;
      if (count !== 4'd15) begin
         n_fail++;
         $display("FAIL full_count: count=%0d required 15", count);
      end
      collect(e, 0);
      finish_idle();
   endtask

   task automatic test_backpressure();
      logic [31:0] w[$];
      logic [7:0]  e[$];
      int          cyc = 0;
      w.push_back(32'h0000_2040);
      e.push_back(8'h20);
      t_ready = 1'b0;
      drive_batch(w, 1'b0);
      @(negedge clk);
      while (!t_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (t_valid !== 1'b1 || out_data !== 8'h20) begin
            n_fail++;
            $display("FAIL hold[%0d]: t_valid=%b out_data=%h required 1 20", i, t_valid, out_data);
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      collect(e, 0);
      finish_idle();
   endtask

   task automatic test_reset_in_run();
      logic [31:0] w[$];
      logic [7:0]  e[$];
      w.push_back(32'h0000_7F7F);
      drive_batch(w, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("reset_in_run");
      release_reset("run_reset");
      w.delete();
      w.push_back(32'h0000_2040);
      e.push_back(8'h20);
      drive_batch(w, 1'b0);
      collect(e, 0);
      finish_idle();
   endtask

   task automatic test_random();
      logic [31:0] w[$];
      logic [7:0]  e[$];
      int          n;
      for (int b = 0; b < 6; b++) begin
         w.delete();
         e.delete();
         n = $urandom_range(15, 1);
         for (int i = 0; i < n; i++) begin
            w.push_back($urandom);
            e.push_back(model_out(w[i]));
         end
         drive_batch(w, 1'b1);
         collect(e, 30);
         finish_idle();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_saturation();
      test_three();
      test_full();
      test_backpressure();
      test_reset_in_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mac_batch_controller.md
MAC_BATCH_CONTROLLER -- requirements
Module: mac_batch_controller

Interface
REQ-001 SHALL provide parameter DEPTH, default 15, meaning the maximum number of words per batch (BRAM addresses 0..14; address 4'hF is the dump address).
REQ-002 SHALL provide parameter RD_LAT, default 1, meaning the number of cycles from a BRAM read enable to valid dout.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 r_valid  input  1  input word valid.
REQ-006 r_last  input  1  marks the final word of a batch; sampled only with r_valid.
REQ-007 in_data  input  32  packed operand word: [7:0]=A, [15:8]=B, [23:16]=C, [31:24] ignored.
REQ-008 r_ready  output  1  controller accepts an input word this cycle.
REQ-009 out_data  output  8  quantized result.
REQ-010 t_valid  output  1  out_data valid.
REQ-011 t_ready  input  1  downstream accepts out_data.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 count  output  4  number of words stored in the current batch.

Function
REQ-014 SHALL instantiate one sram_32x16 and one MAC (A_BITWIDTH=8, OUT_BITWIDTH=16) and sequence both.
REQ-015 SHALL implement states IDLE, LOAD, RD_ISSUE, RD_WAIT, RUN, SEND, DONE.
REQ-016 IDLE: r_ready=1; a word accepted on r_valid is written to address 0, count becomes 1, and the state goes to LOAD, or to RD_ISSUE if r_last=1.
REQ-017 LOAD: each r_valid&r_ready writes in_data to address count and increments count; r_last or count reaching DEPTH moves the state to RD_ISSUE.
REQ-018 r_ready SHALL be 0 in every state other than IDLE and LOAD, and in LOAD when count==DEPTH; words offered then are dropped with no side effect.
REQ-019 RD_ISSUE: the read pointer rp starts at 0; the block asserts bram_en=1 and we=0 at address rp, then goes to RD_WAIT.
REQ-020 RD_WAIT: after RD_LAT cycles, data_a/b/c are latched from dout, the BRAM is idled (address 4'hF), and the state goes to RUN.
REQ-021 RUN: mac_en is held at 1 until MAC DONE; on DONE, mac_en drops the next cycle and the quantized result is registered.
REQ-022 Quantization: out[7]=result[15]; out[6:0]=7'h7F if |result[14:13], otherwise result[12:6].
REQ-023 SEND: t_valid=1 with out_data stable until t_ready=1; on handshake, t_valid=0 the next cycle and rp increments.
REQ-024 After SEND, if rp<count the state returns to RD_ISSUE; otherwise it goes to DONE, then to IDLE one cycle later with count cleared.
REQ-025 t_ready held 0 SHALL stall SEND indefinitely with no loss of data and no change to the BRAM or MAC.
REQ-026 Results SHALL be emitted in write order, exactly one result per stored word.
REQ-027 Whenever the BRAM is not being written or read, bram_en=0, we=0, addr=4'hF, din=0.

Reset
REQ-028 On rstn=0 (asynchronous), the state SHALL become IDLE, and r_ready=0, t_valid=0, out_data=0, busy=0, count=0, mac_en=0, bram_en=0, we=0, addr=4'hF, rp=0, data_a/b/c=0.
REQ-029 r_ready SHALL rise to 1 on the first clock after rstn is deasserted.
REQ-030 A reset during any state SHALL abandon the batch; stale BRAM contents are never emitted afterwards.

Structure
REQ-031 Package mac_ctrl_pkg SHALL hold the state encodings, DUMP_ADDR=4'hF, and the operand field offsets.
REQ-032 Quantization SHALL be a combinational sub-module mac_quant (16-bit input, 8-bit output).

Verification
REQ-033 Single word: in_data=32'h0000_4040 with r_last=1 -> exactly one t_valid with out_data=8'h40.
REQ-034 Saturation: in_data=32'h0000_7F7F with r_last=1 -> out_data=8'h7F.
REQ-035 Three-word batch {32'h4040, 32'h2040, 32'h7F7F} -> outputs 8'h40, 8'h20, 8'h7F in that order, then busy falls.
REQ-036 Full batch: 16 words offered with no r_last -> 15 accepted, r_ready=0 on the 16th, count=15, 15 results emitted.
REQ-037 Backpressure: t_ready held 0 for 10 cycles in SEND -> out_data and t_valid held; one result on release.
REQ-038 Reset asserted in RUN -> all outputs take reset values at once; a following single-word batch produces the correct result only.
